board_renderer: RTL and testbench
=================================

Name: board_renderer

Overview:
- Reads the 10x23 playfield occupancy one row at a time and turns it into a stream of pixel-plot commands for the 160x120 VGA adapter.
- Sits between the game datapath, which owns the board rows and the active tetromino coordinates, and the frame buffer.
- One `start` pulse per frame redraws every cell, as a CELL_SIZE x CELL_SIZE square, in the empty, filled or active colour.

Parameters:
- BOARD_W, 10, columns per row (row word width).
- BOARD_H, 23, rows; row 0 is the bottom row.
- CELL_SIZE, 4, pixel edge of one cell; must be a power of two.
- ORIGIN_X, 60, screen x of the playfield's left edge.
- ORIGIN_Y, 14, screen y of the playfield's top edge.
- COL_EMPTY, 3'b000, colour of an empty cell.
- COL_FILLED, 3'b111, colour of a dropped-block cell.
- COL_ACTIVE, 3'b110, colour of an active-tetromino cell.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous reset, active-high.
- start  in  1  one-cycle request to render one frame.
- row_addr  out  5  board row being read.
- row_data  in  BOARD_W  occupancy of row_addr; bit c is column c; valid one cycle after row_addr changes.
- blk1_x..blk4_x  in  4 each  active tetromino column per block.
- blk1_y..blk4_y  in  5 each  active tetromino row per block.
- plot_x  out  8  pixel x.
- plot_y  out  7  pixel y.
- plot_colour  out  3  pixel colour.
- plot  out  1  plot command valid.
- plot_ready  in  1  adapter accepts the command at this edge.
- busy  out  1  frame in progress.
- done  out  1  one-cycle pulse after the last pixel is accepted.

Behaviour:
- Reset: state IDLE; row_addr, plot_x, plot_y, plot_colour, plot, busy and done all 0. Reset wins in any state, including mid-frame; no further plots are issued.
- FSM states: IDLE, FETCH, WAIT, DRAW, DONE.
- IDLE
  - On `start`: latch all eight block coordinates, set row_addr = BOARD_H-1, assert busy, go to FETCH.
  - `start` while busy is ignored.
- FETCH: drive row_addr for one cycle, go to WAIT.
- WAIT: register row_data into the row buffer, set column = 0, py = 0, px = 0, go to DRAW.
- DRAW
  - plot = 1 with plot_x = ORIGIN_X + column*CELL_SIZE + px and plot_y = ORIGIN_Y + (BOARD_H-1-row)*CELL_SIZE + py.
  - Outputs are held stable until an edge where plot_ready = 1. Only accepted commands advance the counters.
  - Order: px fastest, then py, then column (0..BOARD_W-1). On the last pixel of the row: if row > 0, decrement row_addr and go to FETCH; if row = 0, go to DONE. plot drops to 0 in the same cycle the next state is entered.
- Colour priority:
  - Cell matches any latched (blk_x, blk_y) → COL_ACTIVE.
  - Otherwise row-buffer bit set → COL_FILLED.
  - Otherwise → COL_EMPTY.
  - A block coordinate with y >= BOARD_H or x >= BOARD_W matches no cell.
- DONE: done = 1 for one cycle, busy = 0 in that same cycle, return to IDLE. A `start` in the DONE cycle is ignored.
- Plots per frame: BOARD_W*BOARD_H*CELL_SIZE^2, i.e. 3680 with defaults.
- Arithmetic:
  - Pixel math is unsigned and truncated to 8/7 bits.
  - Elaboration must fail if ORIGIN_X + BOARD_W*CELL_SIZE > 160 or ORIGIN_Y + BOARD_H*CELL_SIZE > 120.
- Block coordinates changing mid-frame have no effect, because they are latched at `start`. row_data is sampled only in WAIT.

Optional Feature:
- Macro CELL_OUTLINE_EN.
- Defined: in filled and active cells, pixels with px = 0, py = 0, px = CELL_SIZE-1 or py = CELL_SIZE-1 use colour 3'b001. Interior pixels keep the normal colour. Empty cells are unchanged. Plot count and timing are unchanged.
- Undefined: all pixels of a cell use the single cell colour.

Test Plan:
- Reset asserted mid-DRAW, plot_ready = 1 → plot, busy, done and row_addr are 0 immediately (asynchronously); no plot accepted after reset; a later `start` renders a full frame of 3680 plots.
- All rows 0, blocks at y = 31, plot_ready = 1, `start` pulse → exactly 3680 plots, all colour 3'b000; first plot at (60,14), last at (99,105); one done pulse; busy high through the frame.
- Row 0 = 10'b0000000001, blocks off-board → the 16 pixels x 60..63, y 102..105 are 3'b111; every other pixel is 3'b000.
- Row 0 bit 0 set, blk1 = (0,0), blk2 = (1,0) → pixels x 60..67, y 102..105 are 3'b110 (active overrides filled).
- plot_ready toggling 1,0,0,1 during DRAW → plot_x, plot_y and plot_colour stable while plot_ready = 0; no pixel skipped or repeated; total still 3680.
- Second `start` 100 cycles into a frame → ignored; exactly one done pulse and 3680 plots.

Source files
------------

// File: rtl/board_renderer.sv
// Renders the 10x23 playfield into CELL_SIZE x CELL_SIZE pixel plot commands, one board row at a time.
// Optional build macro CELL_OUTLINE_EN draws a 3'b001 border around filled and active cells.
module board_renderer #(
  parameter int          BOARD_W    = 10,
  parameter int          BOARD_H    = 23,
  parameter int          CELL_SIZE  = 4,
  parameter int          ORIGIN_X   = 60,
  parameter int          ORIGIN_Y   = 14,
  parameter logic [2:0]  COL_EMPTY  = 3'b000,
  parameter logic [2:0]  COL_FILLED = 3'b111,
  parameter logic [2:0]  COL_ACTIVE = 3'b110
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  output logic [4:0]         row_addr,
  input  logic [BOARD_W-1:0] row_data,
  input  logic [3:0]         blk1_x,
  input  logic [3:0]         blk2_x,
  input  logic [3:0]         blk3_x,
  input  logic [3:0]         blk4_x,
  input  logic [4:0]         blk1_y,
  input  logic [4:0]         blk2_y,
  input  logic [4:0]         blk3_y,
  input  logic [4:0]         blk4_y,
  output logic [7:0]         plot_x,
  output logic [6:0]         plot_y,
  output logic [2:0]         plot_colour,
  output logic               plot,
  input  logic               plot_ready,
  output logic               busy,
  output logic               done,
  output logic [2:0]         dbg_state_o
);

  localparam int PW = (CELL_SIZE > 1) ? $clog2(CELL_SIZE) : 1;

  if (ORIGIN_X + BOARD_W * CELL_SIZE > 160) begin : g_bad_x
    $error("board_renderer: playfield exceeds 160 pixels horizontally");
  end
  if (ORIGIN_Y + BOARD_H * CELL_SIZE > 120) begin : g_bad_y
    $error("board_renderer: playfield exceeds 120 pixels vertically");
  end
  if ((CELL_SIZE & (CELL_SIZE - 1)) != 0) begin : g_bad_cell
    $error("board_renderer: CELL_SIZE must be a power of two");
  end

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    WAIT  = 3'd2,
    DRAW  = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [4:0]         row_q, row_d;
  logic [3:0]         col_q, col_d;
  logic [PW-1:0]      px_q, px_d;
  logic [PW-1:0]      py_q, py_d;
  logic [BOARD_W-1:0] rowbuf_q, rowbuf_d;
  logic [3:0]         bx_q [4];
  logic [4:0]         by_q [4];
  logic               latch_en;

  // Handshake: a plot command transfers on a clock edge where plot and plot_ready
  // are both high; while plot is high and plot_ready low, plot_x/plot_y/plot_colour hold.
  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    col_d    = col_q;
    px_d     = px_q;
    py_d     = py_q;
    rowbuf_d = rowbuf_q;
    latch_en = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          latch_en = 1'b1;
          row_d    = 5'(BOARD_H - 1);
          state_d  = FETCH;
        end
      end
      FETCH: state_d = WAIT;
      WAIT: begin
        rowbuf_d = row_data;
        col_d    = '0;
        px_d     = '0;
        py_d     = '0;
        state_d  = DRAW;
      end
      DRAW: begin
        if (plot_ready) begin
          if (px_q != PW'(CELL_SIZE - 1)) begin
            px_d = px_q + PW'(1);
          end else begin
            px_d = '0;
            if (py_q != PW'(CELL_SIZE - 1)) begin
              py_d = py_q + PW'(1);
            end else begin
              py_d = '0;
              if (col_q != 4'(BOARD_W - 1)) begin
                col_d = col_q + 4'd1;
              end else begin
                col_d = '0;
                if (row_q != 5'd0) begin
                  row_d   = row_q - 5'd1;
                  state_d = FETCH;
                end else begin
                  state_d = DONE;
                end
              end
            end
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      row_q    <= '0;
      col_q    <= '0;
      px_q     <= '0;
      py_q     <= '0;
      rowbuf_q <= '0;
      for (int b = 0; b < 4; b++) begin
        bx_q[b] <= '0;
        by_q[b] <= '0;
      end
    end else begin
      state_q  <= state_d;
      row_q    <= row_d;
      col_q    <= col_d;
      px_q     <= px_d;
      py_q     <= py_d;
      rowbuf_q <= rowbuf_d;
      if (latch_en) begin
        bx_q[0] <= blk1_x;
        bx_q[1] <= blk2_x;
        bx_q[2] <= blk3_x;
        bx_q[3] <= blk4_x;
        by_q[0] <= blk1_y;
        by_q[1] <= blk2_y;
        by_q[2] <= blk3_y;
        by_q[3] <= blk4_y;
      end
    end
  end

  logic       in_draw;
  logic       cell_active;
  logic       cell_filled;
  logic [2:0] colour;
  logic [7:0] pix_x;
  logic [6:0] pix_y;
`ifdef CELL_OUTLINE_EN
  logic       on_edge;
`endif

  // Off-board block coordinates never compare equal to a drawn cell.
  always_comb begin
    cell_active = 1'b0;
    for (int b = 0; b < 4; b++) begin
      if (bx_q[b] == col_q && by_q[b] == row_q &&
          int'(bx_q[b]) < BOARD_W && int'(by_q[b]) < BOARD_H) begin
        cell_active = 1'b1;
      end
    end
  end

  assign cell_filled = rowbuf_q[col_q];

`ifdef CELL_OUTLINE_EN
  assign on_edge = (px_q == '0) || (py_q == '0) ||
                   (px_q == PW'(CELL_SIZE - 1)) || (py_q == PW'(CELL_SIZE - 1));
`endif

  always_comb begin
    colour = COL_EMPTY;
    if (cell_active) begin
      colour = COL_ACTIVE;
    end else if (cell_filled) begin
      colour = COL_FILLED;
    end
`ifdef CELL_OUTLINE_EN
    if ((cell_active || cell_filled) && on_edge) begin
      colour = 3'b001;
    end
`endif
  end

  // Modulo-256/128 arithmetic per term gives the same truncated sum as full-width math.
  assign pix_x = 8'(ORIGIN_X) + 8'(col_q) * 8'(CELL_SIZE) + 8'(px_q);
  assign pix_y = 7'(ORIGIN_Y) + (7'(BOARD_H - 1) - 7'(row_q)) * 7'(CELL_SIZE) + 7'(py_q);

  assign in_draw     = (state_q == DRAW);
  assign plot        = in_draw;
  assign plot_x      = in_draw ? pix_x : '0;
  assign plot_y      = in_draw ? pix_y : '0;
  assign plot_colour = in_draw ? colour : '0;
  assign busy        = (state_q == FETCH) || (state_q == WAIT) || (state_q == DRAW);
  assign done        = (state_q == DONE);
  assign row_addr    = row_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_board_renderer.sv
// Scoreboard bench for board_renderer: frames of expected plots are queued, a monitor pops and compares accepted plots.
module tb_board_renderer;

  localparam int BOARD_W   = 10;
  localparam int BOARD_H   = 23;
  localparam int CELL_SIZE = 4;
  localparam int ORIGIN_X  = 60;
  localparam int ORIGIN_Y  = 14;
  localparam int NPLOT     = BOARD_W * BOARD_H * CELL_SIZE * CELL_SIZE;

  logic         clock = 1'b0;
  logic         reset;
  logic         start;
  logic [4:0]   row_addr;
  logic [9:0]   row_data = '0;
  logic [3:0]   bx [4];
  logic [4:0]   by [4];
  logic [7:0]   plot_x;
  logic [6:0]   plot_y;
  logic [2:0]   plot_colour;
  logic         plot;
  logic         plot_ready;
  logic         busy;
  logic         done;
  logic [2:0]   dbg_state;

  logic [9:0]   board [BOARD_H];
  logic [17:0]  exp_q [$];

  int checks = 0;
  int errors = 0;
  int ready_mode = 0;
  int cyc_cnt = 0;
  int plot_cnt = 0;
  int done_cnt = 0;
  int busy_low = 0;
  logic        hold_v = 1'b0;
  logic [18:0] hold_val = '0;

  board_renderer dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .row_addr    (row_addr),
    .row_data    (row_data),
    .blk1_x      (bx[0]),
    .blk2_x      (bx[1]),
    .blk3_x      (bx[2]),
    .blk4_x      (bx[3]),
    .blk1_y      (by[0]),
    .blk2_y      (by[1]),
    .blk3_y      (by[2]),
    .blk4_y      (by[3]),
    .plot_x      (plot_x),
    .plot_y      (plot_y),
    .plot_colour (plot_colour),
    .plot        (plot),
    .plot_ready  (plot_ready),
    .busy        (busy),
    .done        (done),
    .dbg_state_o (dbg_state)
  );

  // clock / reset / board memory
  always #5 clock = ~clock;

  always @(posedge clock) begin
    row_data <= (int'(row_addr) < BOARD_H) ? board[row_addr] : 10'd0;
  end

  initial begin
    plot_ready = 1'b1;
    forever begin
      @(posedge clock);
      #1;
      cyc_cnt++;
      if (ready_mode == 0) plot_ready = 1'b1;
      else plot_ready = ((cyc_cnt % 4) == 0) || ((cyc_cnt % 4) == 3);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [2:0] exp_colour(input int row, input int col, input int px, input int py);
    logic act;
    logic [2:0] c;
    act = 1'b0;
    for (int b = 0; b < 4; b++) begin
      if (int'(bx[b]) == col && int'(by[b]) == row) act = 1'b1;
    end
    if (act) c = 3'b110;
    else if (board[row][col]) c = 3'b111;
    else c = 3'b000;
`ifdef CELL_OUTLINE_EN
    if (c != 3'b000 && (px == 0 || py == 0 || px == CELL_SIZE - 1 || py == CELL_SIZE - 1)) c = 3'b001;
`else
    if (px < 0 || py < 0) c = 3'b000;
`endif
    return c;
  endfunction

  task automatic push_frame();
    int x;
    int y;
    for (int row = BOARD_H - 1; row >= 0; row--)
      for (int col = 0; col < BOARD_W; col++)
        for (int py = 0; py < CELL_SIZE; py++)
          for (int px = 0; px < CELL_SIZE; px++) begin
            x = ORIGIN_X + col * CELL_SIZE + px;
            y = ORIGIN_Y + (BOARD_H - 1 - row) * CELL_SIZE + py;
            exp_q.push_back({8'(x), 7'(y), exp_colour(row, col, px, py)});
          end
  endtask

  task automatic set_board_zero();
    for (int r = 0; r < BOARD_H; r++) board[r] = 10'd0;
  endtask

  task automatic set_blocks_off();
    for (int b = 0; b < 4; b++) begin
      bx[b] = 4'd0;
      by[b] = 5'd31;
    end
  endtask

  // monitor: pops the scoreboard on every accepted plot
  initial begin
    logic [17:0] e;
    forever begin
      @(negedge clock);
      if (reset) begin
        hold_v = 1'b0;
      end else begin
        if (hold_v) check("hold_stable", {13'd0, plot, plot_x, plot_y, plot_colour}, {13'd0, hold_val});
        hold_v = 1'b0;
        if (plot) begin
          if (!busy) busy_low++;
          if (plot_ready) begin
            plot_cnt++;
            if (exp_q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL unexpected_plot: got x=%0d y=%0d c=%0h expected none", plot_x, plot_y, plot_colour);
            end else begin
              e = exp_q.pop_front();
              check("plot_pixel", {14'd0, plot_x, plot_y, plot_colour}, {14'd0, e});
            end
          end else begin
            hold_v = 1'b1;
            hold_val = {1'b1, plot_x, plot_y, plot_colour};
          end
        end
        if (done) done_cnt++;
      end
    end
  end

  task automatic run_frame(input int mode, input bit extra_start, input bit start_in_done, input bit shuffle);
    bit got;
    plot_cnt = 0;
    done_cnt = 0;
    busy_low = 0;
    ready_mode = mode;
    push_frame();
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    check("busy_after_start", {31'd0, busy}, 32'd1);
    if (shuffle) begin
      bx[0] = 4'd5; by[0] = 5'd3;
      bx[1] = 4'd6; by[1] = 5'd3;
      bx[2] = 4'd0; by[2] = 5'd22;
    end
    got = 1'b0;
    for (int i = 0; i < 20000; i++) begin
      @(negedge clock);
      start = extra_start && (i == 100);
      if (done) begin
        got = 1'b1;
        break;
      end
    end
    start = 1'b0;
    check("done_seen", {31'd0, got}, 32'd1);
    if (got) check("busy_low_in_done", {31'd0, busy}, 32'd0);
    if (start_in_done && got) begin
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      @(negedge clock);
      check("start_in_done_ignored_state", {29'd0, dbg_state}, 32'd0);
      check("start_in_done_ignored_busy", {31'd0, busy}, 32'd0);
    end
    repeat (3) @(negedge clock);
    check("plot_count", plot_cnt, NPLOT);
    check("done_count", done_cnt, 1);
    check("queue_empty", exp_q.size(), 0);
    check("busy_during_plots", busy_low, 0);
    exp_q.delete();
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    set_board_zero();
    set_blocks_off();
    repeat (3) @(negedge clock);
    check("reset_plot", {31'd0, plot}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_row_addr", {27'd0, row_addr}, 32'd0);
    check("reset_plot_xyc", {14'd0, plot_x, plot_y, plot_colour}, 32'd0);
    check("reset_state", {29'd0, dbg_state}, 32'd0);
    reset = 1'b0;

    // reset mid-frame
    ready_mode = 0;
    push_frame();
    @(negedge clock); start = 1'b1;
    @(negedge clock); start = 1'b0;
    repeat (50) @(negedge clock);
    @(posedge clock);
    #1;
    check("mid_draw_plot", {31'd0, plot}, 32'd1);
    #1;
    reset = 1'b1;
    #1;
    check("async_rst_plot", {31'd0, plot}, 32'd0);
    check("async_rst_busy", {31'd0, busy}, 32'd0);
    check("async_rst_done", {31'd0, done}, 32'd0);
    check("async_rst_row_addr", {27'd0, row_addr}, 32'd0);
    check("async_rst_state", {29'd0, dbg_state}, 32'd0);
    exp_q.delete();
    repeat (3) @(negedge clock);
    reset = 1'b0;
    plot_cnt = 0;
    repeat (20) @(negedge clock);
    check("no_plot_after_reset", plot_cnt, 0);

    // empty board, blocks off-board, start during DONE
    run_frame(0, 1'b0, 1'b1, 1'b0);

    // single filled cell at row 0 column 0
    board[0] = 10'b0000000001;
    run_frame(0, 1'b0, 1'b0, 1'b0);

    // active overrides filled; block inputs move after start
    bx[0] = 4'd0; by[0] = 5'd0;
    bx[1] = 4'd1; by[1] = 5'd0;
    bx[2] = 4'd15; by[2] = 5'd31;
    bx[3] = 4'd2; by[3] = 5'd23;
    run_frame(0, 1'b0, 1'b0, 1'b1);

    // plot_ready 1,0,0,1 pattern with a mixed board
    set_board_zero();
    board[5]  = 10'b1010010011;
    board[22] = 10'b1000000001;
    board[11] = 10'b0111111110;
    bx[0] = 4'd3; by[0] = 5'd5;
    bx[1] = 4'd4; by[1] = 5'd5;
    bx[2] = 4'd4; by[2] = 5'd6;
    bx[3] = 4'd9; by[3] = 5'd22;
    run_frame(1, 1'b0, 1'b0, 1'b0);

    // second start mid-frame is ignored
    set_board_zero();
    board[0] = 10'b1100000011;
    set_blocks_off();
    run_frame(0, 1'b1, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
